// File: rtl/mem_ctrl.sv
// mem_ctrl: responder end of the MEM-stage load/store handshake plus a
// lower-priority instruction-fetch port. Each request is serialised into
// byte beats on an 8-bit external RAM; load bytes are assembled
// little-endian and the requester is released by a one-cycle done pulse.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   mem_addr_i     MEM-stage byte address
//   mem_aluop_i    MEM-stage op; only LB/LH/LW/LBU/LHU/SB/SH/SW are requests
//   rt_data_i      store data, low bytes used
//   mem_ctrl_done  one-cycle pulse completing the MEM request
//   rdata          assembled load data, zero above the accessed width
//   if_req_i       fetch request level, held until if_done_o
//   if_addr_i      fetch byte address
//   if_done_o      one-cycle pulse completing the fetch
//   if_inst_o      fetched word
//   ram_addr       RAM byte address
//   ram_dout       RAM write byte
//   ram_din        RAM read byte, valid one cycle after its address
//   ram_wr         1 = write beat, 0 = read/idle
module mem_ctrl #(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr_i,
    input  logic [7:0]            mem_aluop_i,
    input  logic [31:0]           rt_data_i,
    output logic                  mem_ctrl_done,
    output logic [31:0]           rdata,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic                  if_done_o,
    output logic [31:0]           if_inst_o,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  ram_wr
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic SRC_MEM = 1'b0;
    localparam logic SRC_IF  = 1'b1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic [2:0] beats_of(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 3'd1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 3'd2;
            default:                          return 3'd4;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]              nb_q, nb_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    src_q, src_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [31:0]             buf_q, buf_d;

    logic [RAM_ADDR_W-1:0]   ram_addr_d;
    logic [7:0]              ram_dout_d;
    logic                    ram_wr_d;
    logic                    mem_done_d, if_done_d;
    logic [31:0]             rdata_d, inst_d;

    logic [2:0]              cnt_nx;
    logic [RAM_ADDR_W-1:0]   next_addr;
    logic [4:0]              cap_sel, wr_sel;

    // Upper address bits are intentionally dropped: the RAM is smaller
    // than the CPU address space and addresses simply truncate.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:RAM_ADDR_W], if_addr_i[31:RAM_ADDR_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            nb_q          <= '0;
            wdata_q       <= '0;
            src_q         <= SRC_MEM;
            cnt_q         <= '0;
            buf_q         <= '0;
            ram_addr      <= '0;
            ram_dout      <= '0;
            ram_wr        <= 1'b0;
            mem_ctrl_done <= 1'b0;
            if_done_o     <= 1'b0;
            rdata         <= '0;
            if_inst_o     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            nb_q          <= nb_d;
            wdata_q       <= wdata_d;
            src_q         <= src_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            ram_addr      <= ram_addr_d;
            ram_dout      <= ram_dout_d;
            ram_wr        <= ram_wr_d;
            mem_ctrl_done <= mem_done_d;
            if_done_o     <= if_done_d;
            rdata         <= rdata_d;
            if_inst_o     <= inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nb_d       = nb_q;
        wdata_d    = wdata_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ram_addr_d = ram_addr;
        ram_dout_d = ram_dout;
        ram_wr_d   = 1'b0;
        mem_done_d = 1'b0;
        if_done_d  = 1'b0;
        rdata_d    = rdata;
        inst_d     = if_inst_o;

        cnt_nx    = cnt_q + 3'd1;
        next_addr = addr_q + RAM_ADDR_W'(cnt_nx);
        // cnt_q counts cycles spent in READ; the byte presented at beat
        // cnt_q-1 is on ram_din now. Two bits suffice since n <= 4.
        cap_sel   = {cnt_q[1:0] - 2'd1, 3'b000};
        wr_sel    = {cnt_nx[1:0], 3'b000};

        case (state_q)
            IDLE: begin
                // Beat 0 is launched straight from IDLE so the RAM sees it
                // in the first READ/WRITE cycle.
                if (is_load(mem_aluop_i)) begin
                    addr_d     = mem_addr_i[RAM_ADDR_W-1:0];
                    nb_d       = beats_of(mem_aluop_i);
                    src_d      = SRC_MEM;
                    cnt_d      = '0;
                    buf_d      = '0;
                    ram_addr_d = mem_addr_i[RAM_ADDR_W-1:0];
                    state_d    = READ;
                end else if (is_store(mem_aluop_i)) begin
                    addr_d     = mem_addr_i[RAM_ADDR_W-1:0];
                    nb_d       = beats_of(mem_aluop_i);
                    wdata_d    = rt_data_i;
                    src_d      = SRC_MEM;
                    cnt_d      = '0;
                    ram_addr_d = mem_addr_i[RAM_ADDR_W-1:0];
                    ram_dout_d = rt_data_i[7:0];
                    ram_wr_d   = 1'b1;
                    state_d    = WRITE;
                end else if (if_req_i) begin
                    addr_d     = if_addr_i[RAM_ADDR_W-1:0];
                    nb_d       = 3'd4;
                    src_d      = SRC_IF;
                    cnt_d      = '0;
                    buf_d      = '0;
                    ram_addr_d = if_addr_i[RAM_ADDR_W-1:0];
                    state_d    = READ;
                end
            end

            READ: begin
                cnt_d = cnt_nx;
                if (cnt_nx < nb_q) begin
                    ram_addr_d = next_addr;
                end
                if (cnt_q != 3'd0) begin
                    buf_d[cap_sel +: 8] = ram_din;
                end
                // Last byte lands this cycle; publish the merged word so it
                // is visible together with the done pulse.
                if (cnt_q == nb_q) begin
                    state_d = DONE;
                    if (src_q == SRC_IF) begin
                        inst_d    = buf_d;
                        if_done_d = 1'b1;
                    end else begin
                        rdata_d    = buf_d;
                        mem_done_d = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (cnt_nx < nb_q) begin
                    cnt_d      = cnt_nx;
                    ram_addr_d = next_addr;
                    ram_dout_d = wdata_q[wr_sel +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end
            end

            // Done pulse is already on the outputs; requests are ignored
            // here so a still-visible MEM request is not served twice.
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] rt_data_i;
    logic        mem_ctrl_done;
    logic [31:0] rdata;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic [16:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_wr;

    logic        pl_we;
    logic [16:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  ram [0:131071];

    int n_chk  = 0;
    int n_fail = 0;

    mem_ctrl #(.RAM_ADDR_W(17)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr_i   (mem_addr_i),
        .mem_aluop_i  (mem_aluop_i),
        .rt_data_i    (rt_data_i),
        .mem_ctrl_done(mem_ctrl_done),
        .rdata        (rdata),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_done_o    (if_done_o),
        .if_inst_o    (if_inst_o),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .ram_wr       (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        tick();
        check({tag, "_mdone"}, 32'(mem_ctrl_done), 32'd0);
        check({tag, "_idone"}, 32'(if_done_o), 32'd0);
        check({tag, "_wr"}, 32'(ram_wr), 32'd0);
    endtask

    // Steps lat cycles; checks done pulses at md_at/id_at (0 = never) and
    // the beat sequence over cycles bf..bf+nb-1 starting at address base.
    task automatic txn(input string tag, input int lat, input int md_at, input int id_at,
                       input int bf, input int nb, input logic [16:0] base,
                       input bit wr, input logic [31:0] data);
        for (int i = 1; i <= lat; i++) begin
            bit in_beat;
            int k;
            tick();
            in_beat = (i >= bf) && (i < bf + nb);
            k = i - bf;
            check($sformatf("%s_mdone_c%0d", tag, i), 32'(mem_ctrl_done), 32'(i == md_at));
            check($sformatf("%s_idone_c%0d", tag, i), 32'(if_done_o), 32'(i == id_at));
            check($sformatf("%s_wr_c%0d", tag, i), 32'(ram_wr), 32'(wr && in_beat));
            if (in_beat) begin
                logic [16:0] ea;
                ea = base + 17'(k);
                check($sformatf("%s_addr_c%0d", tag, i), 32'(ram_addr), 32'(ea));
                if (wr) check($sformatf("%s_dout_c%0d", tag, i), 32'(ram_dout),
                              (data >> (8 * k)) & 32'hFF);
            end
        end
    endtask

    task automatic mem_req(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        mem_aluop_i = op;
        mem_addr_i  = a;
        rt_data_i   = d;
    endtask

    initial begin
        rst = 1'b0;
        mem_addr_i = '0; mem_aluop_i = OP_NOP; rt_data_i = '0;
        if_req_i = 1'b0; if_addr_i = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        #2;
        preload(17'h00100, 8'h11); preload(17'h00101, 8'h22);
        preload(17'h00102, 8'h33); preload(17'h00103, 8'h44);
        preload(17'h1FFFF, 8'h80); preload(17'h00000, 8'h5A);
        preload(17'h00001, 8'h01); preload(17'h00002, 8'h02);
        preload(17'h00003, 8'h03);
        preload(17'h00010, 8'hA1); preload(17'h00011, 8'hB2);
        preload(17'h00012, 8'hC3); preload(17'h00013, 8'hD4);

        // Reset state
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wr", 32'(ram_wr), 32'd0);
        check("rst_dout", 32'(ram_dout), 32'd0);
        check("rst_mdone", 32'(mem_ctrl_done), 32'd0);
        check("rst_idone", 32'(if_done_o), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_inst", if_inst_o, 32'd0);
        rst = 1'b1;
        idle_chk("post_rst");

        // LW from 0x100
        mem_req(OP_LW, 32'h100, 32'h0);
        txn("lw", 6, 6, 0, 1, 4, 17'h00100, 1'b0, 32'h0);
        check("lw_rdata", rdata, 32'h44332211);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("lw_after1");
        idle_chk("lw_after2");

        // LB at the top of RAM
        mem_req(OP_LB, 32'h1FFFF, 32'h0);
        txn("lb", 3, 3, 0, 1, 1, 17'h1FFFF, 1'b0, 32'h0);
        check("lb_rdata", rdata, 32'h00000080);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("lb_after");

        // LHU wrapping past the top of RAM
        mem_req(OP_LHU, 32'h1FFFF, 32'h0);
        txn("lhu", 4, 4, 0, 1, 2, 17'h1FFFF, 1'b0, 32'h0);
        check("lhu_rdata", rdata, 32'h00005A80);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("lhu_after");

        // SH then read back
        mem_req(OP_SH, 32'h20, 32'hDEADBEEF);
        txn("sh", 3, 3, 0, 1, 2, 17'h00020, 1'b1, 32'hDEADBEEF);
        check("sh_rdata_kept", rdata, 32'h00005A80);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("sh_after");
        mem_req(OP_LHU, 32'h20, 32'h0);
        txn("sh_rb", 4, 4, 0, 1, 2, 17'h00020, 1'b0, 32'h0);
        check("sh_rb_rdata", rdata, 32'h0000BEEF);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("sh_rb_after");

        // SW and fetch in the same cycle: store first
        mem_req(OP_SW, 32'h200, 32'hCAFEF00D);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        txn("sw", 5, 5, 0, 1, 4, 17'h00200, 1'b1, 32'hCAFEF00D);
        check("sw_rdata_kept", rdata, 32'h0000BEEF);
        mem_req(OP_NOP, 32'h0, 32'h0);
        txn("fetch1", 7, 0, 7, 2, 4, 17'h00010, 1'b0, 32'h0);
        check("fetch1_inst", if_inst_o, 32'hD4C3B2A1);
        if_req_i = 1'b0;
        idle_chk("fetch1_after1");
        idle_chk("fetch1_after2");

        // Fetch at 0 with LW arriving one cycle later
        if_req_i = 1'b1; if_addr_i = 32'h0;
        txn("fetch2_a", 1, 0, 0, 1, 1, 17'h00000, 1'b0, 32'h0);
        mem_req(OP_LW, 32'h100, 32'h0);
        txn("fetch2_b", 5, 0, 5, 1, 3, 17'h00001, 1'b0, 32'h0);
        check("fetch2_inst", if_inst_o, 32'h0302015A);
        check("fetch2_rdata_kept", rdata, 32'h0000BEEF);
        if_req_i = 1'b0;
        txn("lw2", 7, 7, 0, 2, 4, 17'h00100, 1'b0, 32'h0);
        check("lw2_rdata", rdata, 32'h44332211);
        check("lw2_inst_kept", if_inst_o, 32'h0302015A);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("lw2_after1");
        idle_chk("lw2_after2");

        // Reset during beat 2 of an LW
        mem_req(OP_LW, 32'h100, 32'h0);
        txn("lw_abort", 3, 0, 0, 1, 3, 17'h00100, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check("mrst_addr", 32'(ram_addr), 32'd0);
        check("mrst_wr", 32'(ram_wr), 32'd0);
        check("mrst_dout", 32'(ram_dout), 32'd0);
        check("mrst_mdone", 32'(mem_ctrl_done), 32'd0);
        check("mrst_idone", 32'(if_done_o), 32'd0);
        check("mrst_rdata", rdata, 32'd0);
        check("mrst_inst", if_inst_o, 32'd0);
        mem_req(OP_NOP, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        idle_chk("mrst_after1");
        idle_chk("mrst_after2");
        idle_chk("mrst_after3");
        mem_req(OP_LB, 32'h103, 32'h0);
        txn("lb_post", 3, 3, 0, 1, 1, 17'h00103, 1'b0, 32'h0);
        check("lb_post_rdata", rdata, 32'h00000044);
        mem_req(OP_NOP, 32'h0, 32'h0);
        idle_chk("lb_post_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
